// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - F/D/E/M/W pipeline sequencer: stage enables, bubbles, PC select, interrupt entry
//
// Purpose: merges load-use stall, data-memory busy, EX branch-taken and the
// external interrupt into per-stage register enables, bubble controls and the
// PC source select. Sequences the reset-vector load and the interrupt entry
// (drain, push PC, push flags, jump to vector).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   stallD, mem_busy           load-use stall request, data memory not ready
//   br_taken, intr             branch taken in EX, interrupt request (level)
//   en_f..en_w                 stage register enables
//   flush_d, flush_e           load bubble into D / E register
//   pc_sel[1:0]                00 PC+1, 01 branch, 10 interrupt vector, 11 reset vector
//   push_pc, push_flags        M stage stack pushes
//   intr_ack                   one-cycle pulse when the interrupt vector is taken
module pipeline_ctrl #(
  parameter int RST_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stallD,
  input  logic       mem_busy,
  input  logic       br_taken,
  input  logic       intr,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       en_m,
  output logic       en_w,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] pc_sel,
  output logic       push_pc,
  output logic       push_flags,
  output logic       intr_ack
);

  localparam logic [2:0] RST_LAST   = 3'(RST_CYCLES - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RST_LD,
    S_RUN,
    S_I_DRAIN,
    S_I_PC,
    S_I_FLAGS,
    S_I_JUMP
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_intr_pend;
  logic       w_intr_pend_nxt;
  logic [4:0] w_en;  // {F, D, E, M, W}

  assign {en_f, en_d, en_e, en_m, en_w} = w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RST_LD;
      r_cnt       <= 3'd0;
      r_intr_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_intr_pend <= w_intr_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_intr_pend_nxt = r_intr_pend | intr;
    w_en            = 5'b00000;
    flush_d         = 1'b0;
    flush_e         = 1'b0;
    pc_sel          = 2'b00;
    push_pc         = 1'b0;
    push_flags      = 1'b0;
    intr_ack        = 1'b0;

    case (r_state)
      S_RST_LD: begin
        // Only F is clocked so the reset vector lands in PC; mem_busy has no say.
        w_en    = 5'b10000;
        flush_d = 1'b1;
        flush_e = 1'b1;
        pc_sel  = 2'b11;
        if (r_cnt == RST_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end

      S_RUN: begin
        if (mem_busy) begin
          // freeze the whole pipe, nothing else decided this cycle
        end else if (br_taken) begin
          // stallD comes from a wrong-path instruction, so it is dropped
          w_en    = 5'b11111;
          flush_d = 1'b1;
          flush_e = 1'b1;
          pc_sel  = 2'b01;
        end else if (stallD) begin
          w_en    = 5'b00111;
          flush_e = 1'b1;
        end else begin
          w_en = 5'b11111;
          if (r_intr_pend || intr) begin
            w_state_nxt = S_I_DRAIN;
            w_cnt_nxt   = 3'd0;
          end
        end
      end

      S_I_DRAIN: begin
        if (!mem_busy) begin
          w_en    = 5'b01111;
          flush_d = 1'b1;
          if (r_cnt == DRAIN_LAST) begin
            w_state_nxt = S_I_PC;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end

      S_I_PC: begin
        if (!mem_busy) begin
          w_en        = 5'b01111;
          flush_d     = 1'b1;
          push_pc     = 1'b1;
          w_state_nxt = S_I_FLAGS;
        end
      end

      S_I_FLAGS: begin
        if (!mem_busy) begin
          w_en        = 5'b01111;
          flush_d     = 1'b1;
          push_flags  = 1'b1;
          w_state_nxt = S_I_JUMP;
        end
      end

      S_I_JUMP: begin
        if (!mem_busy) begin
          w_en            = 5'b11111;
          flush_d         = 1'b1;
          pc_sel          = 2'b10;
          intr_ack        = 1'b1;
          w_intr_pend_nxt = 1'b0;
          w_state_nxt     = S_RUN;
        end
      end

      default: begin
        w_state_nxt = S_RST_LD;
        w_cnt_nxt   = 3'd0;
      end
    endcase

    // While reset is held the registers already sit in RST_LD; mask en_f so
    // the outputs show the reset values rather than the RST_LD values.
    if (!rst_n) begin
      w_en       = 5'b00000;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      pc_sel     = 2'b11;
      push_pc    = 1'b0;
      push_flags = 1'b0;
      intr_ack   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic       stallD;
  logic       mem_busy;
  logic       br_taken;
  logic       intr;
  logic       en_f, en_d, en_e, en_m, en_w;
  logic       flush_d, flush_e;
  logic [1:0] pc_sel;
  logic       push_pc, push_flags, intr_ack;

  int passed = 0;
  int total  = 0;

  // Observed vector: {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e, pc_sel, push_pc,push_flags,intr_ack}
  logic [12:0] obs;
  assign obs = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, pc_sel, push_pc, push_flags, intr_ack};

  localparam logic [12:0] V_RESET = 13'b00000_11_11_000;
  localparam logic [12:0] V_RSTLD = 13'b10000_11_11_000;
  localparam logic [12:0] V_RUN   = 13'b11111_00_00_000;
  localparam logic [12:0] V_STALL = 13'b00111_01_00_000;
  localparam logic [12:0] V_BR    = 13'b11111_11_01_000;
  localparam logic [12:0] V_BUSY  = 13'b00000_00_00_000;
  localparam logic [12:0] V_DRAIN = 13'b01111_10_00_000;
  localparam logic [12:0] V_IPC   = 13'b01111_10_00_100;
  localparam logic [12:0] V_IFL   = 13'b01111_10_00_010;
  localparam logic [12:0] V_IJMP  = 13'b11111_10_10_001;

  pipeline_ctrl #(.RST_CYCLES(2), .DRAIN_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallD     (stallD),
    .mem_busy   (mem_busy),
    .br_taken   (br_taken),
    .intr       (intr),
    .en_f       (en_f),
    .en_d       (en_d),
    .en_e       (en_e),
    .en_m       (en_m),
    .en_w       (en_w),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .pc_sel     (pc_sel),
    .push_pc    (push_pc),
    .push_flags (push_flags),
    .intr_ack   (intr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Drive one cycle's inputs at the falling edge, then sample the
  // combinational outputs shortly after.
  task automatic step(input logic rst, input logic stl, input logic bsy,
                      input logic br, input logic irq,
                      input logic [12:0] exp, input string tag);
    @(negedge clk);
    rst_n    = rst;
    stallD   = stl;
    mem_busy = bsy;
    br_taken = br;
    intr     = irq;
    #1;
    check(tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; stallD = 1'b0; mem_busy = 1'b0; br_taken = 1'b0; intr = 1'b0;

    // reset and reset-vector load
    step(0, 0, 0, 0, 0, V_RESET, "reset_hold");
    step(0, 0, 1, 1, 0, V_RESET, "reset_hold_inputs");
    step(1, 0, 0, 0, 0, V_RSTLD, "rst_ld_c1");
    step(1, 0, 1, 0, 0, V_RSTLD, "rst_ld_c2_busy_ignored");
    step(1, 0, 0, 0, 0, V_RUN,   "run_first");

    // load-use stall
    step(1, 1, 0, 0, 0, V_STALL, "stall");
    step(1, 0, 0, 0, 0, V_RUN,   "after_stall");

    // branch beats stall
    step(1, 1, 0, 1, 0, V_BR,    "branch_and_stall");
    step(1, 0, 0, 0, 0, V_RUN,   "after_branch");

    // busy overrides branch and stall
    step(1, 1, 1, 1, 0, V_BUSY,  "busy_over_all");
    step(1, 0, 0, 0, 0, V_RUN,   "after_busy");

    // interrupt entry from idle RUN: ack 6 cycles after the pulse
    step(1, 0, 0, 0, 1, V_RUN,   "irq_seen");
    step(1, 0, 0, 0, 0, V_DRAIN, "drain1");
    step(1, 1, 0, 1, 0, V_DRAIN, "drain2_ignore_br_stall");
    step(1, 0, 0, 0, 0, V_DRAIN, "drain3");
    step(1, 0, 0, 0, 0, V_IPC,   "push_pc");
    step(1, 0, 0, 0, 0, V_IFL,   "push_flags");
    step(1, 0, 0, 0, 0, V_IJMP,  "jump_ack");
    step(1, 0, 0, 0, 0, V_RUN,   "back_run");
    step(1, 0, 0, 0, 0, V_RUN,   "no_reentry");

    // interrupt raised while busy is remembered; busy during I_PC defers the push
    step(1, 0, 1, 0, 1, V_BUSY,  "irq_while_busy");
    step(1, 0, 0, 0, 0, V_RUN,   "irq_pend_advance");
    step(1, 0, 0, 0, 0, V_DRAIN, "b_drain1");
    step(1, 0, 0, 0, 0, V_DRAIN, "b_drain2");
    step(1, 0, 0, 0, 0, V_DRAIN, "b_drain3");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, V_BUSY, "ipc_busy");
    step(1, 0, 0, 0, 0, V_IPC,   "b_push_pc");
    step(1, 0, 0, 0, 0, V_IFL,   "b_push_flags");
    step(1, 0, 1, 0, 0, V_BUSY,  "ijump_busy");
    step(1, 0, 0, 0, 0, V_IJMP,  "b_jump_ack");
    step(1, 0, 0, 0, 0, V_RUN,   "b_back_run");

    // reset in the middle of the drain drops the interrupt
    step(1, 0, 0, 0, 1, V_RUN,   "r_irq_seen");
    step(1, 0, 0, 0, 0, V_DRAIN, "r_drain1");
    step(0, 0, 0, 0, 0, V_RESET, "reset_mid_drain");
    step(1, 0, 0, 0, 0, V_RSTLD, "r_rst_ld_c1");
    step(1, 0, 0, 0, 0, V_RSTLD, "r_rst_ld_c2");
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, V_RUN, "r_run_no_ack");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
